// File: rtl/ascii_cmd_pkg.sv
// Types and character-class helpers for the ASCII motor command parser.
package ascii_cmd_pkg;

  import ascii_inst_pkg::*;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SIGN    = 3'd1,
    ST_DIGITS  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_DISCARD = 3'd4
  } parser_state_t;

  typedef enum logic [1:0] {
    ERR_BAD_CHAR  = 2'd0,
    ERR_NO_DIGITS = 2'd1,
    ERR_TOO_LONG  = 2'd2,
    ERR_OVERFLOW  = 2'd3
  } err_code_t;

  function automatic logic is_digit(input logic [7:0] ch);
    return (ch >= _0) && (ch <= _9);
  endfunction

  function automatic logic is_upper(input logic [7:0] ch);
    return (ch >= _A) && (ch <= _Z);
  endfunction

  function automatic logic is_lower(input logic [7:0] ch);
    return (ch >= _a) && (ch <= _z);
  endfunction

  function automatic logic is_sign(input logic [7:0] ch);
    return (ch == _PLUS) || (ch == _MINUS);
  endfunction

endpackage

// File: rtl/ascii_inst_pkg.sv
// Shared ASCII character constants used by the character writer and the command parser.
package ascii_inst_pkg;

  localparam logic [7:0] _0               = 8'h30;
  localparam logic [7:0] _9               = 8'h39;
  localparam logic [7:0] _A               = 8'h41;
  localparam logic [7:0] _Z               = 8'h5A;
  localparam logic [7:0] _a               = 8'h61;
  localparam logic [7:0] _z               = 8'h7A;
  localparam logic [7:0] _PLUS            = 8'h2B;
  localparam logic [7:0] _MINUS           = 8'h2D;
  localparam logic [7:0] _SPACE           = 8'h20;
  localparam logic [7:0] _LINE_FEED       = 8'h0A;
  localparam logic [7:0] _CARRIAGE_RETURN = 8'h0D;

  // Distance between a lowercase letter and its uppercase form.
  localparam logic [7:0] CASE_OFFSET      = 8'h20;

endpackage

// File: rtl/ascii_dec_mac.sv
// Decimal multiply-accumulate: acc*10 + digit via shift-add, flagged when the result exceeds a limit.
module ascii_dec_mac #(
  parameter int ACC_W = 20
) (
  input  logic [ACC_W-1:0] i_acc,
  input  logic [3:0]       i_digit,
  input  logic [ACC_W-1:0] i_limit,
  output logic [ACC_W-1:0] o_result,
  output logic             o_overflow
);

  localparam int EXT_W = ACC_W + 4;

  logic [EXT_W-1:0] w_times8;
  logic [EXT_W-1:0] w_times2;
  logic [EXT_W-1:0] w_digit;
  logic [EXT_W-1:0] w_sum;

  // Four guard bits keep the product exact even when the accumulator is at full width.
  assign w_times8   = {1'b0, i_acc, 3'b000};
  assign w_times2   = {3'b000, i_acc, 1'b0};
  assign w_digit    = {{(EXT_W-4){1'b0}}, i_digit};
  assign w_sum      = w_times8 + w_times2 + w_digit;

  assign o_result   = w_sum[ACC_W-1:0];
  assign o_overflow = (w_sum > {4'b0000, i_limit});

endmodule

// File: rtl/ascii_cmd_parser.sv
// Parses "<OP>[+|-]<digits><LF>" lines from the UART receiver into an opcode and a signed value.
module ascii_cmd_parser
  import ascii_inst_pkg::*;
  import ascii_cmd_pkg::*;
#(
  parameter int VAL_W      = 16,
  parameter int MAX_DIGITS = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_valid,
  output logic             o_rx_ready,
  output logic             o_cmd_valid,
  input  logic             i_cmd_ready,
  output logic [7:0]       o_cmd_op,
  output logic [VAL_W-1:0] o_cmd_value,
  output logic             o_err_valid,
  output logic [1:0]       o_err_code
);

  localparam int ACC_W = VAL_W + 4;
  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  // Negative magnitudes may reach 2^(VAL_W-1); positives stop one short of it.
  localparam logic [ACC_W-1:0] LIMIT   = ACC_W'(1) << (VAL_W - 1);
  localparam logic [ACC_W-1:0] POS_MAX = LIMIT - ACC_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

  parser_state_t    r_state;
  logic [7:0]       r_op;
  logic             r_neg;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  logic             r_cmd_valid;
  logic [7:0]       r_cmd_op;
  logic [VAL_W-1:0] r_cmd_value;
  logic             r_err_valid;
  err_code_t        r_err_code;

  logic             w_rx_ready;
  logic             w_accept;
  logic             w_byte_in;
  logic             w_is_lf;
  logic             w_is_digit;
  logic [3:0]       w_digit;
  logic [ACC_W-1:0] w_mac_result;
  logic             w_mac_overflow;
  logic [VAL_W-1:0] w_signed_value;

  assign w_rx_ready = (r_state != ST_HOLD);
  assign w_accept   = i_rx_valid & w_rx_ready;
  assign w_byte_in  = w_accept & (i_rx_data != _CARRIAGE_RETURN);
  assign w_is_lf    = (i_rx_data == _LINE_FEED);
  assign w_is_digit = is_digit(i_rx_data);
  assign w_digit    = i_rx_data[3:0];

  ascii_dec_mac #(
    .ACC_W (ACC_W)
  ) u_mac (
    .i_acc      (r_acc),
    .i_digit    (w_digit),
    .i_limit    (LIMIT),
    .o_result   (w_mac_result),
    .o_overflow (w_mac_overflow)
  );

  // Two's complement of the magnitude; a magnitude of 2^(VAL_W-1) maps onto the most negative value.
  assign w_signed_value = r_neg ? (~r_acc[VAL_W-1:0] + 1'b1) : r_acc[VAL_W-1:0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_op        <= '0;
      r_neg       <= 1'b0;
      r_acc       <= '0;
      r_count     <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_op    <= '0;
      r_cmd_value <= '0;
      r_err_valid <= 1'b0;
      r_err_code  <= ERR_BAD_CHAR;
    end else begin
      r_err_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_byte_in) begin
            if (is_upper(i_rx_data)) begin
              r_op    <= i_rx_data;
              r_state <= ST_SIGN;
            end else if (is_lower(i_rx_data)) begin
              r_op    <= i_rx_data - CASE_OFFSET;
              r_state <= ST_SIGN;
            end else if (!w_is_lf) begin
              r_err_valid <= 1'b1;
              r_err_code  <= ERR_BAD_CHAR;
              r_state     <= ST_DISCARD;
            end
          end
        end

        ST_SIGN: begin
          if (w_byte_in) begin
            if (is_sign(i_rx_data)) begin
              r_neg   <= (i_rx_data == _MINUS);
              r_state <= ST_DIGITS;
            end else if (w_is_digit) begin
              r_acc   <= {{(ACC_W-4){1'b0}}, w_digit};
              r_count <= CNT_W'(1);
              r_state <= ST_DIGITS;
            end else if (w_is_lf) begin
              r_err_valid <= 1'b1;
              r_err_code  <= ERR_NO_DIGITS;
              r_neg       <= 1'b0;
              r_acc       <= '0;
              r_count     <= '0;
              r_state     <= ST_IDLE;
            end else begin
              r_err_valid <= 1'b1;
              r_err_code  <= ERR_BAD_CHAR;
              r_state     <= ST_DISCARD;
            end
          end
        end

        // Digit-length is checked before overflow so a sixth digit always reports TOO_LONG.
        ST_DIGITS: begin
          if (w_byte_in) begin
            if (w_is_digit) begin
              if (r_count == CNT_MAX) begin
                r_err_valid <= 1'b1;
                r_err_code  <= ERR_TOO_LONG;
                r_state     <= ST_DISCARD;
              end else if (w_mac_overflow) begin
                r_err_valid <= 1'b1;
                r_err_code  <= ERR_OVERFLOW;
                r_state     <= ST_DISCARD;
              end else begin
                r_acc   <= w_mac_result;
                r_count <= r_count + CNT_W'(1);
              end
            end else if (w_is_lf) begin
              if (r_count == '0) begin
                r_err_valid <= 1'b1;
                r_err_code  <= ERR_NO_DIGITS;
                r_state     <= ST_IDLE;
              end else if (!r_neg && (r_acc > POS_MAX)) begin
                r_err_valid <= 1'b1;
                r_err_code  <= ERR_OVERFLOW;
                r_state     <= ST_IDLE;
              end else begin
                r_cmd_op    <= r_op;
                r_cmd_value <= w_signed_value;
                r_cmd_valid <= 1'b1;
                r_state     <= ST_HOLD;
              end
              r_neg   <= 1'b0;
              r_acc   <= '0;
              r_count <= '0;
            end else begin
              r_err_valid <= 1'b1;
              r_err_code  <= ERR_BAD_CHAR;
              r_state     <= ST_DISCARD;
            end
          end
        end

        ST_HOLD: begin
          if (i_cmd_ready) begin
            r_cmd_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end

        ST_DISCARD: begin
          if (w_byte_in && w_is_lf) begin
            r_neg   <= 1'b0;
            r_acc   <= '0;
            r_count <= '0;
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_neg   <= 1'b0;
          r_acc   <= '0;
          r_count <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_rx_ready  = w_rx_ready;
  assign o_cmd_valid = r_cmd_valid;
  assign o_cmd_op    = r_cmd_op;
  assign o_cmd_value = r_cmd_value;
  assign o_err_valid = r_err_valid;
  assign o_err_code  = r_err_code;

endmodule

// File: tb/tb_ascii_cmd_parser.sv
// Self-checking bench for ascii_cmd_parser: table-driven lines plus hand-written multi-cycle sequences.
module tb_ascii_cmd_parser;

  localparam int VAL_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       rxData = '0;
  logic             rxValid = 1'b0;
  logic             rxReady;
  logic             cmdValid;
  logic             cmdReady = 1'b1;
  logic [7:0]       cmdOp;
  logic [VAL_W-1:0] cmdValue;
  logic             errValid;
  logic [1:0]       errCode;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit               isErr;
    logic [7:0]       op;
    logic [VAL_W-1:0] value;
    logic [1:0]       code;
  } exp_t;

  typedef struct {
    string      line;
    bit         hasEvt;
    bit         isErr;
    logic [7:0] op;
    int         value;
    logic [1:0] code;
  } vec_t;

  exp_t expQ[$];
  vec_t vecs[$];

  ascii_cmd_parser #(
    .VAL_W      (VAL_W),
    .MAX_DIGITS (5)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rx_data   (rxData),
    .i_rx_valid  (rxValid),
    .o_rx_ready  (rxReady),
    .o_cmd_valid (cmdValid),
    .i_cmd_ready (cmdReady),
    .o_cmd_op    (cmdOp),
    .o_cmd_value (cmdValue),
    .o_err_valid (errValid),
    .o_err_code  (errCode)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushExp(input bit isErr, input logic [7:0] op, input int value, input logic [1:0] code);
    exp_t e;
    e.isErr = isErr;
    e.op    = op;
    e.value = VAL_W'(value);
    e.code  = code;
    expQ.push_back(e);
  endtask

  task automatic addVec(input string line, input bit hasEvt, input bit isErr,
                        input logic [7:0] op, input int value, input logic [1:0] code);
    vec_t v;
    v.line   = line;
    v.hasEvt = hasEvt;
    v.isErr  = isErr;
    v.op     = op;
    v.value  = value;
    v.code   = code;
    vecs.push_back(v);
  endtask

  // Drives one byte and returns 1 time unit after the edge that consumed it.
  task automatic applyStimulus(input logic [7:0] b);
    int guard = 0;
    rxData  = b;
    rxValid = 1'b1;
    while (!rxReady && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!rxReady) begin
      checks++;
      errors++;
      $display("[TB] FAIL rx_ready_timeout actual=0 expected=1 byte=0x%0h", b);
    end
    @(posedge clk);
    #1;
    rxValid = 1'b0;
  endtask

  task automatic sendLine(input string s);
    for (int i = 0; i < s.len(); i++) applyStimulus(s[i]);
  endtask

  // Scoreboard: every error pulse and every accepted command pops the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (errValid) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_err actual=code%0d expected=no_event", errCode);
        end else begin
          e = expQ.pop_front();
          checkOutput("evt_kind_err", {31'b0, errValid}, {31'b0, e.isErr});
          if (e.isErr) checkOutput("err_code", {30'b0, errCode}, {30'b0, e.code});
        end
      end
      if (cmdValid && cmdReady) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_cmd actual=op0x%0h val0x%0h expected=no_event", cmdOp, cmdValue);
        end else begin
          e = expQ.pop_front();
          checkOutput("evt_kind_cmd", {31'b0, cmdValid}, {31'b0, !e.isErr});
          if (!e.isErr) begin
            checkOutput("cmd_op", {24'b0, cmdOp}, {24'b0, e.op});
            checkOutput("cmd_value", {16'b0, cmdValue}, {16'b0, e.value});
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    addVec("s-32768\015\n", 1, 0, 8'h53, -32768, 2'd0);
    addVec("S32768\n",      1, 1, 8'h00, 0,      2'd3);
    addVec("P123456\n",     1, 1, 8'h00, 0,      2'd2);
    addVec("P7\n",          1, 0, 8'h50, 7,      2'd0);
    addVec("X1?2?\n",       1, 1, 8'h00, 0,      2'd0);
    addVec("\n",            0, 0, 8'h00, 0,      2'd0);
    addVec("Q\n",           1, 1, 8'h00, 0,      2'd1);
    addVec("Q-\n",          1, 1, 8'h00, 0,      2'd1);
    addVec("Z+\n",          1, 1, 8'h00, 0,      2'd1);
    addVec("d-0\n",         1, 0, 8'h44, 0,      2'd0);
    addVec("T32767\n",      1, 0, 8'h54, 32767,  2'd0);
    addVec("N-32769\n",     1, 1, 8'h00, 0,      2'd3);
    addVec("J99999\n",      1, 1, 8'h00, 0,      2'd3);
    addVec("1\n",           1, 1, 8'h00, 0,      2'd0);
    addVec("K+12\n",        1, 0, 8'h4B, 12,     2'd0);
    addVec("R00042\n",      1, 0, 8'h52, 42,     2'd0);
    addVec("Ga5\n",         1, 1, 8'h00, 0,      2'd0);
    addVec("e-\0157\n",     1, 0, 8'h45, -7,     2'd0);
    addVec("U12\015x\n",    1, 1, 8'h00, 0,      2'd0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_rx_ready",  {31'b0, rxReady},  32'd1);
    checkOutput("rst_cmd_valid", {31'b0, cmdValid}, 32'd0);
    checkOutput("rst_cmd_op",    {24'b0, cmdOp},    32'd0);
    checkOutput("rst_cmd_value", {16'b0, cmdValue}, 32'd0);
    checkOutput("rst_err_valid", {31'b0, errValid}, 32'd0);
    checkOutput("rst_err_code",  {30'b0, errCode},  32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Latency: command visible right after the edge that consumed LF.
    pushExp(0, 8'h4D, 1234, 2'd0);
    sendLine("M1234\n");
    checkOutput("lat_cmd_valid", {31'b0, cmdValid}, 32'd1);
    checkOutput("lat_rx_ready",  {31'b0, rxReady},  32'd0);
    checkOutput("lat_err_valid", {31'b0, errValid}, 32'd0);

    foreach (vecs[i]) begin
      if (vecs[i].hasEvt) pushExp(vecs[i].isErr, vecs[i].op, vecs[i].value, vecs[i].code);
      sendLine(vecs[i].line);
    end

    // Backpressure: command held while the next line waits behind it.
    repeat (3) @(posedge clk);
    #1;
    cmdReady = 1'b0;
    pushExp(0, 8'h41, 5, 2'd0);
    sendLine("A5\n");
    pushExp(0, 8'h42, 6, 2'd0);
    fork
      sendLine("B6\n");
      begin
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          checkOutput("bp_cmd_valid", {31'b0, cmdValid}, 32'd1);
          checkOutput("bp_rx_ready",  {31'b0, rxReady},  32'd0);
          checkOutput("bp_cmd_op",    {24'b0, cmdOp},    32'h41);
          checkOutput("bp_cmd_value", {16'b0, cmdValue}, 32'd5);
        end
        @(posedge clk);
        #1;
        cmdReady = 1'b1;
      end
    join

    // Reset mid-line drops the partial command without reporting anything.
    repeat (3) @(posedge clk);
    #1;
    sendLine("V12");
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_rx_ready",  {31'b0, rxReady},  32'd1);
    checkOutput("mid_rst_cmd_valid", {31'b0, cmdValid}, 32'd0);
    checkOutput("mid_rst_cmd_op",    {24'b0, cmdOp},    32'd0);
    checkOutput("mid_rst_cmd_value", {16'b0, cmdValue}, 32'd0);
    checkOutput("mid_rst_err_valid", {31'b0, errValid}, 32'd0);
    checkOutput("mid_rst_err_code",  {30'b0, errCode},  32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    pushExp(0, 8'h56, 3, 2'd0);
    sendLine("V3\n");

    repeat (5) @(posedge clk);
    #1;
    checkOutput("queue_drained", expQ.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
